bin2bcd_seq: RTL and testbench

//  Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).

---
 rtl/bin2bcd_seq.sv | 118 +++++++++++
 tb/tb_bin2bcd_seq.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: shift-and-add-3, one input bit per clock.
// Result and overflow flag are registered and only change on the done pulse.

module bin2bcd_add3 (
   input  logic [3:0] dig_i,
   output logic [3:0] dig_o
);
   // Per-digit pre-shift correction; 9+3 fits in 4 bits, so no carry out.
   assign dig_o = (dig_i >= 4'd5) ? dig_i + 4'd3 : dig_i;
endmodule

module bin2bcd_seq #(
   parameter int BIN_W  = 27,
   parameter int DIGITS = 8
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf
);
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int CAT_W = 4*DIGITS + BIN_W;

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_e;

   state_e                     state_q, state_d;
   logic [BIN_W-1:0]           sh_q, sh_d;
   logic [DIGITS-1:0][3:0]     work_q, work_d;
   logic [DIGITS-1:0][3:0]     work_adj;
   logic                       sticky_q, sticky_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [DIGITS-1:0][3:0]     bcd_q, bcd_d;
   logic                       ovf_q, ovf_d;
   logic                       done_q, done_d;
   logic                       busy_q;
   logic [CAT_W-1:0]           cat;

   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      bin2bcd_add3 u_add3 (
         .dig_i (work_q[g]),
         .dig_o (work_adj[g])
      );
   end

   assign cat = {work_adj, sh_q} << 1;

   always_comb begin
      state_d  = state_q;
      sh_d     = sh_q;
      work_d   = work_q;
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
      bcd_d    = bcd_q;
      ovf_d    = ovf_q;
      done_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               sh_d     = bin;
               work_d   = '0;
               sticky_d = 1'b0;
               cnt_d    = '0;
               state_d  = S_CONV;
            end
         end
         S_CONV: begin
            // Bit falling off the top digit means the value needs another digit.
            sticky_d = sticky_q | work_adj[DIGITS-1][3];
            work_d   = cat[CAT_W-1:BIN_W];
            sh_d     = cat[BIN_W-1:0];
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(BIN_W - 1))
               state_d = S_DONE;
         end
         S_DONE: begin
            bcd_d   = sticky_q ? {DIGITS{4'h9}} : work_q;
            ovf_d   = sticky_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         sh_q     <= '0;
         work_q   <= '0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
         bcd_q    <= '0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sh_q     <= sh_d;
         work_q   <= work_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
         bcd_q    <= bcd_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
         busy_q   <= (state_d != S_IDLE);
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign bcd  = bcd_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: latency, overflow saturation, back-to-back
// throughput, input isolation during conversion and mid-conversion reset.

module tb_bin2bcd_seq;
   logic        clock = 1'b0;
   logic        resetn;
   logic        start;
   logic [26:0] bin;
   logic        busy;
   logic        done;
   logic [31:0] bcd;
   logic        ovf;

   int checks   = 0;
   int failures = 0;

   bin2bcd_seq #(.BIN_W(27), .DIGITS(8)) dut (
      .clock  (clock),
      .resetn (resetn),
      .start  (start),
      .bin    (bin),
      .busy   (busy),
      .done   (done),
      .bcd    (bcd),
      .ovf    (ovf)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One conversion: start sampled at edge 0, done expected after edge 28.
   task automatic do_conv(input logic [26:0] b, input bit scramble,
                          input logic [31:0] eb, input logic eo, input string tag);
      logic [31:0] prev;
      int          n;
      bit          stable;
      @(negedge clock);
      start = 1'b1;
      bin   = b;
      prev  = bcd;
      @(posedge clock);
      #1;
      start = 1'b0;
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      n      = 0;
      stable = 1'b1;
      while (n < 40 && !done) begin
         if (scramble) bin = 27'($urandom);
         @(posedge clock);
         #1;
         n++;
         if (!done && bcd !== prev) stable = 1'b0;
      end
      chk({tag, "_lat"}, 64'(n), 64'd28);
      chk({tag, "_bcd"}, 64'(bcd), 64'(eb));
      chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
      chk({tag, "_hold"}, 64'(stable), 64'd1);
      @(posedge clock);
      #1;
      chk({tag, "_pulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      int dn[3];
      int nd;
      int lowcnt;
      int ndone;

      // 1: reset state, then zero
      resetn = 1'b0;
      start  = 1'b0;
      bin    = '0;
      #2;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_bcd",  64'(bcd),  64'd0);
      chk("rst_ovf",  64'(ovf),  64'd0);
      #18 resetn = 1'b1;
      do_conv(27'd0, 1'b0, 32'h00000000, 1'b0, "zero");

      // 2, 3: typical values and overflow boundary
      do_conv(27'd12345678,  1'b0, 32'h12345678, 1'b0, "t12345678");
      do_conv(27'd99999999,  1'b0, 32'h99999999, 1'b0, "t99999999");
      do_conv(27'd100000000, 1'b0, 32'h99999999, 1'b1, "t1e8");
      do_conv(27'd7,         1'b0, 32'h00000007, 1'b0, "t7");

      // 4: start held high -> one conversion every 29 cycles
      @(negedge clock);
      start  = 1'b1;
      bin    = 27'd42;
      nd     = 0;
      lowcnt = 0;
      for (int k = 0; k <= 86; k++) begin
         @(posedge clock);
         #1;
         if (done) begin
            if (nd < 3) dn[nd] = k;
            nd++;
            chk("b2b_bcd", 64'(bcd), 64'h42);
         end
         if (!busy) lowcnt++;
         if (k == 86) start = 1'b0;
      end
      chk("b2b_ndone", 64'(nd), 64'd3);
      chk("b2b_d0", 64'(dn[0]), 64'd28);
      chk("b2b_d1", 64'(dn[1]), 64'd57);
      chk("b2b_d2", 64'(dn[2]), 64'd86);
      chk("b2b_busylow", 64'(lowcnt), 64'd3);

      // 5: max input saturates; bin changes during conversion are ignored
      do_conv(27'd134217727, 1'b0, 32'h99999999, 1'b1, "tmax");
      do_conv(27'd7,         1'b1, 32'h00000007, 1'b0, "scramble");

      // 6: reset at CONV cycle 10 aborts without a done pulse
      @(negedge clock);
      start = 1'b1;
      bin   = 27'd12345678;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clock);
      #2;
      resetn = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_bcd",  64'(bcd),  64'd0);
      chk("abort_ovf",  64'(ovf),  64'd0);
      chk("abort_done", 64'(done), 64'd0);
      @(negedge clock);
      resetn = 1'b1;
      ndone  = 0;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (done) ndone++;
      end
      chk("abort_nodone", 64'(ndone), 64'd0);
      chk("abort_idle", 64'(busy), 64'd0);
      do_conv(27'd21, 1'b0, 32'h00000021, 1'b0, "after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
